// File: rtl/rast_iter_pkg.sv
// Shared types and helpers for the raster sample iterator: sizes, scan states,
// one-hot subsample rate codes and the rate-to-step conversion.
package rast_iter_pkg;

  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;

  typedef enum logic {
    WAIT,
    TEST
  } iter_state_t;

  localparam logic [3:0] SS_1  = 4'b1000;
  localparam logic [3:0] SS_4  = 4'b0100;
  localparam logic [3:0] SS_16 = 4'b0010;
  localparam logic [3:0] SS_64 = 4'b0001;

  // Anything that is not a legal one-hot code falls back to one sample per pixel.
  function automatic logic signed [SIGFIG-1:0] step_from_ss(input logic [3:0] rate);
    logic signed [SIGFIG-1:0] s;
    s = '0;
    case (rate)
      SS_4:    s[RADIX-1] = 1'b1;
      SS_16:   s[RADIX-2] = 1'b1;
      SS_64:   s[RADIX-3] = 1'b1;
      default: s[RADIX]   = 1'b1;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sample_advance.sv
// Combinational next-sample calculation for the raster walk. Sums are one bit
// wider than the coordinates so the compare against the upper-right corner never wraps.
module sample_advance
  import rast_iter_pkg::*;
(
  input  logic signed [SIGFIG-1:0] x,
  input  logic signed [SIGFIG-1:0] y,
  input  logic signed [SIGFIG-1:0] ll_x,
  input  logic signed [SIGFIG-1:0] ur_x,
  input  logic signed [SIGFIG-1:0] ur_y,
  input  logic signed [SIGFIG-1:0] step,
  output logic signed [SIGFIG-1:0] x_nxt,
  output logic signed [SIGFIG-1:0] y_nxt,
  output logic                     row_end,
  output logic                     last
);

  logic signed [SIGFIG:0] x_e, y_e, ur_x_e, ur_y_e, step_e, x_sum, y_sum;

  assign x_e    = $signed({x[SIGFIG-1], x});
  assign y_e    = $signed({y[SIGFIG-1], y});
  assign ur_x_e = $signed({ur_x[SIGFIG-1], ur_x});
  assign ur_y_e = $signed({ur_y[SIGFIG-1], ur_y});
  assign step_e = $signed({step[SIGFIG-1], step});

  assign x_sum = x_e + step_e;
  assign y_sum = y_e + step_e;

  assign row_end = x_sum > ur_x_e;
  assign x_nxt   = row_end ? ll_x : x_sum[SIGFIG-1:0];
  assign y_nxt   = y_sum[SIGFIG-1:0];

  // The current sample can only lie beyond the upper-right corner when the box
  // is inverted, in which case the single ll sample is also the last one.
  assign last = (row_end && (y_sum > ur_y_e)) || (x_e > ur_x_e) || (y_e > ur_y_e);

endmodule

// File: rtl/sample_scan_iterator.sv
// Walks a raster grid of sample points inside a triangle's bounding box.
// Optional RAST_ITER_BACK2BACK_EN lets the next box be accepted on the last sample cycle.
module sample_scan_iterator
  import rast_iter_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
  input  logic [COLORS-1:0][SIGFIG-1:0]          color_R13U,
  input  logic [1:0][1:0][SIGFIG-1:0]            box_R13S,
  input  logic                                  validTri_R13H,
  input  logic [3:0]                            subSample_RnnnnU,
  output logic                                  halt_RnnnnnL,
  output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
  output logic [COLORS-1:0][SIGFIG-1:0]          color_R14U,
  output logic [1:0][SIGFIG-1:0]                 sample_R14S,
  output logic                                  validSamp_R14H
);

`ifdef RAST_ITER_BACK2BACK_EN
  localparam bit BACK2BACK = 1'b1;
`else
  localparam bit BACK2BACK = 1'b0;
`endif

  iter_state_t              state;
  logic signed [SIGFIG-1:0] x, y, ll_x, ur_x, ur_y, step;
  logic signed [SIGFIG-1:0] x_nxt, y_nxt;
  logic                     row_end, last, accept;

  sample_advance u_advance (
    .x       (x),
    .y       (y),
    .ll_x    (ll_x),
    .ur_x    (ur_x),
    .ur_y    (ur_y),
    .step    (step),
    .x_nxt   (x_nxt),
    .y_nxt   (y_nxt),
    .row_end (row_end),
    .last    (last)
  );

  // Depends only on registered state, so there is no input-to-output path.
  assign halt_RnnnnnL = (state == WAIT) || (BACK2BACK && (state == TEST) && last);
  assign accept       = validTri_R13H && halt_RnnnnnL;

  assign sample_R14S[0] = x;
  assign sample_R14S[1] = y;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= WAIT;
      tri_R14S       <= '0;
      color_R14U     <= '0;
      x              <= '0;
      y              <= '0;
      ll_x           <= '0;
      ur_x           <= '0;
      ur_y           <= '0;
      step           <= '0;
      validSamp_R14H <= 1'b0;
    end else if (accept) begin
      state          <= TEST;
      tri_R14S       <= tri_R13S;
      color_R14U     <= color_R13U;
      x              <= box_R13S[0][0];
      y              <= box_R13S[0][1];
      ll_x           <= box_R13S[0][0];
      ur_x           <= box_R13S[1][0];
      ur_y           <= box_R13S[1][1];
      step           <= step_from_ss(subSample_RnnnnU);
      validSamp_R14H <= 1'b1;
    end else begin
      case (state)
        TEST: begin
          if (last) begin
            state          <= WAIT;
            validSamp_R14H <= 1'b0;
          end else begin
            x <= x_nxt;
            if (row_end) y <= y_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_scan_iterator.sv
// Self-checking bench for sample_scan_iterator: directed boxes, boundaries,
// mid-scan reset, back-to-back boxes and randomized boxes against a loop model.
module tb_sample_scan_iterator;
  import rast_iter_pkg::*;

`ifdef RAST_ITER_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  typedef logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0]          color_t;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  tri_t                      tri_R13S = '0;
  color_t                    color_R13U = '0;
  logic [1:0][1:0][SIGFIG-1:0] box_R13S = '0;
  logic                      validTri_R13H = 1'b0;
  logic [3:0]                subSample_RnnnnU = 4'b1000;
  logic                      halt_RnnnnnL;
  tri_t                      tri_R14S;
  color_t                    color_R14U;
  logic [1:0][SIGFIG-1:0]    sample_R14S;
  logic                      validSamp_R14H;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_x[$];
  int exp_y[$];

  always #5 clk = ~clk;

  sample_scan_iterator dut (
    .clk              (clk),
    .rst              (rst),
    .tri_R13S         (tri_R13S),
    .color_R13U       (color_R13U),
    .box_R13S         (box_R13S),
    .validTri_R13H    (validTri_R13H),
    .subSample_RnnnnU (subSample_RnnnnU),
    .halt_RnnnnnL     (halt_RnnnnnL),
    .tri_R14S         (tri_R14S),
    .color_R14U       (color_R14U),
    .sample_R14S      (sample_R14S),
    .validSamp_R14H   (validSamp_R14H)
  );

  function automatic int model_step(input logic [3:0] rate);
    case (rate)
      4'b1000: return 1024;
      4'b0100: return 512;
      4'b0010: return 256;
      4'b0001: return 128;
      default: return 1024;
    endcase
  endfunction

  // Expected sample list: raster order over the box, or just ll if inverted.
  task automatic model_box(input int llx, input int lly, input int urx, input int ury, input int step);
    exp_x.delete();
    exp_y.delete();
    if (llx > urx || lly > ury) begin
      exp_x.push_back(llx);
      exp_y.push_back(lly);
    end else begin
      for (int yy = lly; yy <= ury; yy += step)
        for (int xx = llx; xx <= urx; xx += step) begin
          exp_x.push_back(xx);
          exp_y.push_back(yy);
        end
    end
  endtask

  task automatic rand_tri(output tri_t t, output color_t c);
    for (int i = 0; i < VERTS; i++)
      for (int j = 0; j < AXIS; j++) t[i][j] = SIGFIG'($urandom());
    for (int i = 0; i < COLORS; i++) c[i] = SIGFIG'($urandom());
  endtask

  task automatic drive_box(input int llx, input int lly, input int urx, input int ury,
                           input logic [3:0] rate, input tri_t t, input color_t c);
    tri_R13S         = t;
    color_R13U       = c;
    box_R13S[0][0]   = SIGFIG'(llx);
    box_R13S[0][1]   = SIGFIG'(lly);
    box_R13S[1][0]   = SIGFIG'(urx);
    box_R13S[1][1]   = SIGFIG'(ury);
    subSample_RnnnnU = rate;
    validTri_R13H    = 1'b1;
  endtask

  task automatic scramble_inputs();
    tri_t   t;
    color_t c;
    rand_tri(t, c);
    tri_R13S   = t;
    color_R13U = c;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) box_R13S[i][j] = SIGFIG'($urandom());
    subSample_RnnnnU = 4'($urandom());
  endtask

  // Presents one box for a single cycle and checks every emitted sample.
  task automatic run_box(input string name, input int llx, input int lly, input int urx,
                         input int ury, input logic [3:0] rate);
    tri_t   t;
    color_t c;
    int     n;
    logic   exp_h;
    rand_tri(t, c);
    model_box(llx, lly, urx, ury, model_step(rate));
    n = exp_x.size();
    @(negedge clk);
    drive_box(llx, lly, urx, ury, rate, t, c);
    @(negedge clk);
    validTri_R13H = 1'b0;
    scramble_inputs();
    for (int i = 0; i < n; i++) begin
      exp_h = (i == n - 1) ? B2B : 1'b0;
      n_checks++;
      if (validSamp_R14H !== 1'b1 || sample_R14S[0] !== SIGFIG'(exp_x[i]) ||
          sample_R14S[1] !== SIGFIG'(exp_y[i])) begin
        n_fail++;
        $display("FAIL %s sample %0d: got valid=%0b (%h,%h) want valid=1 (%h,%h)", name, i,
                 validSamp_R14H, sample_R14S[0], sample_R14S[1], SIGFIG'(exp_x[i]), SIGFIG'(exp_y[i]));
      end
      n_checks++;
      if (halt_RnnnnnL !== exp_h) begin
        n_fail++;
        $display("FAIL %s halt at sample %0d: got %0b want %0b", name, i, halt_RnnnnnL, exp_h);
      end
      n_checks++;
      if (tri_R14S !== t || color_R14U !== c) begin
        n_fail++;
        $display("FAIL %s latched tri/color at sample %0d: got tri0=%h col0=%h want tri0=%h col0=%h",
                 name, i, tri_R14S[0][0], color_R14U[0], t[0][0], c[0]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (validSamp_R14H !== 1'b0 || halt_RnnnnnL !== 1'b1) begin
      n_fail++;
      $display("FAIL %s after box: got valid=%0b halt=%0b want valid=0 halt=1", name,
               validSamp_R14H, halt_RnnnnnL);
    end
  endtask

  task automatic check_idle_zero(input string name);
    n_checks++;
    if (validSamp_R14H !== 1'b0 || halt_RnnnnnL !== 1'b1 || sample_R14S !== '0 ||
        tri_R14S !== '0 || color_R14U !== '0) begin
      n_fail++;
      $display("FAIL %s: got valid=%0b halt=%0b sample=(%h,%h) tri0=%h want 0,1,(0,0),0", name,
               validSamp_R14H, halt_RnnnnnL, sample_R14S[0], sample_R14S[1], tri_R14S[0][0]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    check_idle_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_zero("post_reset_idle");
  endtask

  task automatic test_one_spp();
    run_box("one_spp", 0, 0, 'h800, 'h400, 4'b1000);
  endtask

  task automatic test_four_spp();
    run_box("four_spp", 0, 0, 'h200, 'h200, 4'b0100);
    run_box("sixteen_spp", 'h400, 'h400, 'h700, 'h500, 4'b0010);
    run_box("sixtyfour_spp", 0, 0, 'h100, 'h80, 4'b0001);
  endtask

  task automatic test_boundary();
    run_box("ll_eq_ur", 'hC00, 'h400, 'hC00, 'h400, 4'b1000);
    run_box("inverted_x", 'h800, 0, 'h400, 0, 4'b1000);
    run_box("inverted_y", 0, 'h800, 'h800, 'h400, 4'b1000);
    run_box("near_max_x", 'h7FFC00, 0, 'h7FFFFF, 'h400, 4'b1000);
    run_box("bad_rate", 0, 0, 'h400, 'h400, 4'b1100);
  endtask

  // Box A is followed by box B with validTri held high throughout; B's tri
  // must not disturb A's scan, and the gap between boxes depends on the build.
  task automatic test_back_to_back();
    tri_t   ta, tb;
    color_t ca, cb;
    int     gap;
    int     c;
    gap = B2B ? 0 : 1;
    rand_tri(ta, ca);
    rand_tri(tb, cb);
    @(negedge clk);
    drive_box(0, 0, 'h400, 0, 4'b1000, ta, ca);
    @(negedge clk);
    drive_box('h1000, 'h400, 'h1400, 'h400, 4'b1000, tb, cb);
    for (c = 0; c <= 4 + gap; c++) begin
      n_checks++;
      if (c < 2) begin
        if (validSamp_R14H !== 1'b1 || sample_R14S[0] !== SIGFIG'(c * 'h400) ||
            sample_R14S[1] !== '0 || tri_R14S !== ta) begin
          n_fail++;
          $display("FAIL b2b box A cycle %0d: got valid=%0b x=%h tri_ok=%0b want valid=1 x=%h tri_ok=1",
                   c, validSamp_R14H, sample_R14S[0], tri_R14S === ta, SIGFIG'(c * 'h400));
        end
      end else if (c < 2 + gap || c == 4 + gap) begin
        if (validSamp_R14H !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b gap cycle %0d: got valid=%0b want 0", c, validSamp_R14H);
        end
      end else begin
        if (validSamp_R14H !== 1'b1 || sample_R14S[0] !== SIGFIG'('h1000 + (c - 2 - gap) * 'h400) ||
            sample_R14S[1] !== SIGFIG'('h400) || tri_R14S !== tb) begin
          n_fail++;
          $display("FAIL b2b box B cycle %0d: got valid=%0b x=%h y=%h tri_ok=%0b want valid=1 x=%h y=400",
                   c, validSamp_R14H, sample_R14S[0], sample_R14S[1], tri_R14S === tb,
                   SIGFIG'('h1000 + (c - 2 - gap) * 'h400));
        end
      end
      if (c == 2 + gap) validTri_R13H = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    tri_t   t;
    color_t c;
    rand_tri(t, c);
    model_box(0, 0, 'h800, 'h400, 1024);
    @(negedge clk);
    drive_box(0, 0, 'h800, 'h400, 4'b1000, t, c);
    @(negedge clk);
    validTri_R13H = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (validSamp_R14H !== 1'b1 || sample_R14S[0] !== SIGFIG'(exp_x[i]) ||
          sample_R14S[1] !== SIGFIG'(exp_y[i])) begin
        n_fail++;
        $display("FAIL reset_mid pre sample %0d: got valid=%0b (%h,%h) want (%h,%h)", i,
                 validSamp_R14H, sample_R14S[0], sample_R14S[1], SIGFIG'(exp_x[i]), SIGFIG'(exp_y[i]));
      end
      if (i < 2) @(negedge clk);
    end
    rst = 1'b0;
    #1;
    check_idle_zero("reset_mid_async");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle_zero("reset_mid_no_resume");
    end
    run_box("after_reset", 'h400, 'h400, 'h800, 'h400, 4'b1000);
  endtask

  task automatic test_random();
    logic [3:0] rates[5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0110};
    for (int k = 0; k < 25; k++) begin
      logic [3:0] rate;
      int s, llx, lly, urx, ury, ex, ey;
      rate = rates[$urandom_range(0, 4)];
      s = model_step(rate);
      llx = $urandom_range(0, 64);
      llx = (llx - 32) * s;
      lly = $urandom_range(0, 64);
      lly = (lly - 32) * s;
      ex = $urandom_range(0, 5);
      ey = $urandom_range(0, 5);
      urx = (ex == 5) ? llx - 1 : llx + ex * s + $urandom_range(0, s - 1);
      ury = (ey == 5) ? lly - s : lly + ey * s + $urandom_range(0, s - 1);
      run_box("random", llx, lly, urx, ury, rate);
    end
  endtask

  initial begin
    test_reset();
    test_one_spp();
    test_four_spp();
    test_boundary();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
